spi_arb: RTL and testbench
==========================

Name: spi_arb

Overview:
Round-robin arbiter and sequencer that shares one SPI memory controller among NREQ requesters.
- Captures one requester's command (wr/addr/din).
- Pre-checks the address.
- Issues a single start pulse to the controller and waits for done or err, with a timeout.
- Routes the completion status and read data back to the granted requester.
- Sits between the client agents and the SPI controller/memory path.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_LIMIT, 32, addresses >= ADDR_LIMIT are rejected locally, with no controller access
TIMEOUT, 1024, max cycles in WAIT before the transaction is aborted with error

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester request level
req_wr  input  NREQ  1 = write, 0 = read, per requester
req_addr  input  8*NREQ  address; requester i uses bits [8i+7:8i]
req_din  input  8*NREQ  write data, same packing as req_addr
gnt  output  NREQ  one-hot, one-cycle pulse: command of requester i captured
rsp_done  output  NREQ  one-hot, one-cycle pulse: transaction of requester i finished
rsp_err  output  NREQ  same cycle as rsp_done; 1 = transaction failed
rsp_dout  output  8  read data; valid in the rsp_done cycle of a successful read
busy  output  1  high in every state except IDLE
ctrl_start  output  1  one-cycle pulse: controller begins a transaction
ctrl_wr  output  1  latched command mode
ctrl_addr  output  8  latched address
ctrl_din  output  8  latched write data
ctrl_done  input  1  controller completion pulse
ctrl_err  input  1  controller error pulse
ctrl_dout  input  8  controller read data; valid with ctrl_done

Behaviour:
- Reset (synchronous): all outputs are 0, state = IDLE, round-robin pointer ptr = 0, timer = 0. Reset mid-transaction aborts immediately:
  - no rsp_done is issued;
  - a late ctrl_done/ctrl_err arriving after reset is ignored.
- States: IDLE, CHECK, WAIT, RESP.
- IDLE (busy = 0):
  - If any req bit is set, select the first set bit searching ptr, ptr+1, ... (mod NREQ).
  - Latch idx, wr, addr and din into the ctrl_* registers.
  - Pulse gnt[idx] for one cycle and go to CHECK.
  - With no req, stay in IDLE.
- CHECK:
  - If addr >= ADDR_LIMIT: set the error flag and go to RESP; ctrl_start is never asserted.
  - Otherwise: pulse ctrl_start for one cycle, clear the timer and go to WAIT.
- WAIT:
  - Timer increments every cycle.
  - On ctrl_err: error = 1, go to RESP.
  - On ctrl_done without ctrl_err: error = 0; if the command is a read, capture ctrl_dout into the rsp_dout register; go to RESP.
  - If ctrl_done and ctrl_err arrive in the same cycle, err wins and rsp_dout is not updated.
  - If timer == TIMEOUT-1 with no completion: error = 1, go to RESP. A completion arriving in that same cycle takes precedence over the timeout.
- RESP:
  - Pulse rsp_done[idx] for one cycle; rsp_err[idx] = error flag in the same cycle.
  - Set ptr <= (idx+1) mod NREQ, clear the error flag and go to IDLE.
- Latency: req sampled at cycle 0 → gnt at cycle 1 → ctrl_start at cycle 2. A rejected address gives rsp_done + rsp_err at cycle 3.
- ctrl_* outputs hold their latched values from the gnt cycle through RESP.
- Requests:
  - req is level-sensitive; a requester keeps req high until it sees gnt.
  - Between gnt and rsp_done, req from all requesters is ignored (one outstanding transaction).
  - req still high in the IDLE cycle after RESP counts as a new request.
- rsp_dout holds the last successful read value. Writes and errors leave it unchanged. Reset value is 0.
- ctrl_done/ctrl_err seen in IDLE, CHECK or RESP are ignored.
- Timer width is clog2(TIMEOUT)+1 bits; no wrap, since the timeout fires first.

Test Plan:
- Single write: req[0] with wr=1, addr=0x05, din=0xA5 → gnt[0] at cycle 1, ctrl_start at cycle 2 with ctrl_addr=0x05, ctrl_din=0xA5; ctrl_done after 20 cycles → rsp_done[0]=1, rsp_err[0]=0 the next cycle.
- Single read: req[2] with wr=0, addr=0x1F; ctrl_done with ctrl_dout=0x3C → rsp_done[2]=1, rsp_dout=0x3C.
- Fairness: req=4'b1111 held for four transactions from reset → grant order 0,1,2,3. Then req=4'b1001 → grant 0, then 3, then 0.
- Bad address: addr=0x20 on req[1] → gnt[1], no ctrl_start, rsp_done[1]=rsp_err[1]=1 at cycle 3.
- Timeout and collision:
  - No ctrl_done for TIMEOUT cycles → rsp_err=1 and busy drops.
  - ctrl_done and ctrl_err together with ctrl_dout=0xFF → rsp_err=1 and rsp_dout keeps its previous value.
- Reset mid-WAIT: rst pulsed 5 cycles after ctrl_start, then ctrl_done pulses → no rsp_done, all outputs 0, busy=0, and the next request is arbitrated from ptr=0.

Source files
------------

// File: rtl/spi_arb.sv
// Round-robin arbiter/sequencer sharing one SPI memory controller.
// One outstanding transaction; status and read data return to the grantee.
module spi_arb #(
  parameter int NREQ       = 4,
  parameter int ADDR_LIMIT = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_wr,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_din,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rsp_done,
  output logic [NREQ-1:0] rsp_err,
  output logic [7:0]      rsp_dout,
  output logic            busy,
  output logic            ctrl_start,
  output logic            ctrl_wr,
  output logic [7:0]      ctrl_addr,
  output logic [7:0]      ctrl_din,
  input  logic            ctrl_done,
  input  logic            ctrl_err,
  input  logic [7:0]      ctrl_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [8:0]    LIMIT = 9'(ADDR_LIMIT);
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] I_MAX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_CHECK, S_WAIT, S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      din_q, din_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      dout_q, dout_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            start_q, start_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] rerr_q, rerr_d;
  logic [IW-1:0]   sel;

  // Lowest rotation offset from ptr wins: scan offsets high to low
  function automatic logic [IW-1:0] rr_pick(
    input logic [NREQ-1:0] r,
    input logic [IW-1:0]   p
  );
    logic [IW-1:0] s;
    int j;
    s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NREQ) j = j - NREQ;
      if (r[j]) s = IW'(j);
    end
    return s;
  endfunction

  assign sel = rr_pick(req, ptr_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    err_d   = err_q;
    timer_d = timer_q;
    dout_d  = dout_q;
    gnt_d   = '0;
    start_d = 1'b0;
    done_d  = '0;
    rerr_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          idx_d   = sel;
          wr_d    = req_wr[sel];
          addr_d  = req_addr[8*int'(sel) +: 8];
          din_d   = req_din[8*int'(sel) +: 8];
          gnt_d   = NREQ'(1) << sel;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ({1'b0, addr_q} >= LIMIT) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          start_d = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (ctrl_err) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (ctrl_done) begin
          err_d   = 1'b0;
          if (!wr_q) dout_d = ctrl_dout;
          state_d = S_RESP;
        end else if (timer_q == T_END) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        done_d  = NREQ'(1) << idx_q;
        rerr_d  = err_q ? (NREQ'(1) << idx_q) : '0;
        ptr_d   = (idx_q == I_MAX) ? '0 : idx_q + 1'b1;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
      dout_q  <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      done_q  <= '0;
      rerr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      dout_q  <= dout_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      done_q  <= done_d;
      rerr_q  <= rerr_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_done   = done_q;
  assign rsp_err    = rerr_q;
  assign rsp_dout   = dout_q;
  assign busy       = (state_q != S_IDLE);
  assign ctrl_start = start_q;
  assign ctrl_wr    = wr_q;
  assign ctrl_addr  = addr_q;
  assign ctrl_din   = din_q;

endmodule

// File: tb/tb_spi_arb.sv
// Randomized bench for spi_arb against a transaction-level model.
// Model tracks rotation pointer and last good read value only.
module tb_spi_arb;

  localparam int N  = 4;
  localparam int AL = 32;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, req_wr;
  logic [8*N-1:0] req_addr, req_din;
  logic [N-1:0] gnt, rsp_done, rsp_err;
  logic [7:0]   rsp_dout;
  logic         busy, ctrl_start, ctrl_wr;
  logic [7:0]   ctrl_addr, ctrl_din;
  logic         ctrl_done, ctrl_err;
  logic [7:0]   ctrl_dout;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;
  logic [7:0] dout_m = 8'h00;

  spi_arb #(.NREQ(N), .ADDR_LIMIT(AL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_din(req_din),
    .gnt(gnt), .rsp_done(rsp_done),
    .rsp_err(rsp_err), .rsp_dout(rsp_dout),
    .busy(busy), .ctrl_start(ctrl_start),
    .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr),
    .ctrl_din(ctrl_din), .ctrl_done(ctrl_done),
    .ctrl_err(ctrl_err), .ctrl_dout(ctrl_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  // mode: 0 done, 1 err, 2 done+err, 3 silent (timeout)
  // called at a negedge while the DUT is idle
  task automatic txn(input logic [N-1:0] mask,
                     input logic [N-1:0] wrv,
                     input logic [8*N-1:0] av,
                     input logic [8*N-1:0] dv,
                     input int mode, input int d,
                     input logic [7:0] rdat);
    int g, lat, exp_lat;
    logic w, e;
    logic [7:0] a;
    g = pick(mask);
    w = wrv[g];
    a = av[8*g +: 8];
    req = mask; req_wr = wrv;
    req_addr = av; req_din = dv;
    @(negedge clk);
    chk("gnt", gnt, 32'(1) << g);
    chk("ctrl_wr", ctrl_wr, w);
    chk("ctrl_addr", ctrl_addr, a);
    chk("ctrl_din", ctrl_din, dv[8*g +: 8]);
    chk("busy_chk", busy, 1);
    req[g] = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      ctrl_done = 1'b1;
      ctrl_dout = 8'h77;
    end
    @(negedge clk);
    ctrl_done = 1'b0;
    ctrl_err  = 1'b0;
    ptr_m = (g + 1) % N;
    if (a >= AL) begin
      chk("start_bad", ctrl_start, 0);
      @(negedge clk);
      chk("done_bad", rsp_done, 32'(1) << g);
      chk("err_bad", rsp_err, 32'(1) << g);
      chk("dout_bad", rsp_dout, dout_m);
      chk("busy_bad", busy, 0);
      return;
    end
    chk("start", ctrl_start, 1);
    lat = -1;
    for (int k = 0; k < 2*TO + 8; k++) begin
      if (mode != 3 && k == d) begin
        ctrl_done = (mode != 1);
        ctrl_err  = (mode != 0);
        ctrl_dout = rdat;
      end
      @(negedge clk);
      ctrl_done = 1'b0;
      ctrl_err  = 1'b0;
      ctrl_dout = 8'($urandom);
      if (k == 0) chk("start_pulse", ctrl_start, 0);
      if (rsp_done != '0) begin
        lat = k + 1;
        break;
      end
    end
    exp_lat = (mode == 3) ? TO + 1 : d + 2;
    e = (mode != 0);
    if (mode == 0 && !w) dout_m = rdat;
    chk("latency", lat, exp_lat);
    chk("done", rsp_done, 32'(1) << g);
    chk("err", rsp_err, e ? (32'(1) << g) : 0);
    chk("dout", rsp_dout, dout_m);
    chk("busy_end", busy, 0);
  endtask

  task automatic one(input int i, input logic w,
                     input logic [7:0] a,
                     input logic [7:0] dn,
                     input int mode, input int d,
                     input logic [7:0] rdat);
    logic [8*N-1:0] av, dv;
    logic [N-1:0] wv;
    av = {$urandom, $urandom};
    dv = {$urandom, $urandom};
    wv = N'($urandom);
    av[8*i +: 8] = a;
    dv[8*i +: 8] = dn;
    wv[i] = w;
    txn(N'(1) << i, wv, av, dv, mode, d, rdat);
  endtask

  task automatic rnd_txn(input logic [N-1:0] mask);
    logic [8*N-1:0] av, dv;
    int r, mode, d;
    for (int i = 0; i < N; i++)
      av[8*i +: 8] = ($urandom_range(0, 3) == 0) ?
        8'($urandom_range(AL, 255)) :
        8'($urandom_range(0, AL - 1));
    dv = {$urandom, $urandom};
    r = $urandom_range(0, 9);
    d = $urandom_range(0, 12);
    mode = 0;
    if (r == 6) mode = 1;
    if (r == 7) mode = 2;
    if (r == 8) mode = 3;
    if (r == 9) d = TO - 1;
    txn(mask, N'($urandom), av, dv,
        mode, d, 8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    dout_m = 8'h00;
  endtask

  initial begin
    logic [N-1:0] seen;
    rst = 1'b1;
    req = '0; req_wr = '0;
    req_addr = '0; req_din = '0;
    ctrl_done = 1'b0; ctrl_err = 1'b0;
    ctrl_dout = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", rsp_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", ctrl_start, 0);
    chk("rst_addr", ctrl_addr, 0);
    chk("rst_dout", rsp_dout, 0);
    rst = 1'b0;

    one(0, 1'b1, 8'h05, 8'hA5, 0, 20, 8'h11);
    one(2, 1'b0, 8'h1F, 8'h00, 0, 3, 8'h3C);

    do_reset();
    for (int t = 0; t < 4; t++) rnd_txn(4'b1111);
    for (int t = 0; t < 3; t++) rnd_txn(4'b1001);

    one(1, 1'b0, 8'h20, 8'h00, 0, 0, 8'h00);
    one(3, 1'b0, 8'h02, 8'h00, 3, 0, 8'h00);
    one(0, 1'b0, 8'h07, 8'h00, 2, 4, 8'hFF);
    one(1, 1'b0, 8'h08, 8'h00, 0, TO - 1, 8'hC3);
    one(2, 1'b0, 8'h09, 8'h00, 0, 1, 8'h5A);

    // abort during WAIT; ptr is 3 here
    req = 4'b1000;
    req_wr = '0;
    req_addr = {8'h10, 24'h0};
    @(negedge clk);
    chk("abort_gnt", gnt, 4'b1000);
    req = '0;
    @(negedge clk);
    chk("abort_start", ctrl_start, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ctrl_done = 1'b1;
    ctrl_dout = 8'h99;
    @(negedge clk);
    ctrl_done = 1'b0;
    seen = '0;
    for (int k = 0; k < 4; k++) begin
      seen = seen | rsp_done;
      @(negedge clk);
    end
    chk("abort_nodone", seen, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ctrl", {ctrl_wr, ctrl_addr, ctrl_din}, 0);
    chk("abort_dout", rsp_dout, 0);
    chk("abort_gnt0", gnt, 0);
    ptr_m = 0;
    dout_m = 8'h00;
    rnd_txn(4'b1010);

    for (int t = 0; t < 150; t++)
      rnd_txn(N'($urandom_range(1, (1 << N) - 1)));
    req = '0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
